// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and pixel logic (slave).
// The slave side owns the pixel clock-enable. The master side drives everything else.
interface vga_timing_if #(
    parameter int CNT_W   = 11,
    parameter int FRAME_W = 8
);
    logic               ce;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [CNT_W-1:0]   pix_x;
    logic [CNT_W-1:0]   pix_y;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  ce,
        output hsync,
        output vsync,
        output de,
        output pix_x,
        output pix_y,
        output line_start,
        output frame_start,
        output frame_count
    );

    modport slave (
        output ce,
        input  hsync,
        input  vsync,
        input  de,
        input  pix_x,
        input  pix_y,
        input  line_start,
        input  frame_start,
        input  frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator driven by a pixel clock-enable.
// Every output is registered and describes the (h,v) position loaded on the last ce edge.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int CNT_W     = 11,
    parameter int FRAME_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic             HS_ACT   = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic             VS_ACT   = (VS_POL != 0) ? 1'b1 : 1'b0;

    logic [CNT_W-1:0]   h_r;
    logic [CNT_W-1:0]   v_r;
    logic [CNT_W-1:0]   pix_x_r;
    logic [CNT_W-1:0]   pix_y_r;
    logic               de_r;
    logic               hsync_r;
    logic               vsync_r;
    logic               line_start_r;
    logic               frame_start_r;
    logic [FRAME_W-1:0] frame_count_r;
    logic               started_r;

    logic               h_last_s;
    logic               v_last_s;
    logic               at_origin_s;
    logic [CNT_W-1:0]   h_next_s;
    logic [CNT_W-1:0]   v_next_s;
    logic               de_s;
    logic               hsync_s;
    logic               vsync_s;

    // Position decode of the current counters and their successors.
    always_comb begin
        h_last_s    = (h_r == H_LAST);
        v_last_s    = (v_r == V_LAST);
        at_origin_s = (h_r == '0) && (v_r == '0);

        if (h_last_s) begin
            h_next_s = '0;
        end else begin
            h_next_s = h_r + CNT_W'(1);
        end

        // v only moves on the h wrap, so vsync can only change where x becomes 0.
        if (!h_last_s) begin
            v_next_s = v_r;
        end else if (v_last_s) begin
            v_next_s = '0;
        end else begin
            v_next_s = v_r + CNT_W'(1);
        end

        de_s = (h_r < H_VIS) && (v_r < V_VIS);

        if ((h_r >= HS_START) && (h_r < HS_END)) begin
            hsync_s = HS_ACT;
        end else begin
            hsync_s = ~HS_ACT;
        end

        if ((v_r >= VS_START) && (v_r < VS_END)) begin
            vsync_s = VS_ACT;
        end else begin
            vsync_s = ~VS_ACT;
        end
    end

    // Counter advance and output registers; strobes self-clear every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r           <= '0;
            v_r           <= '0;
            pix_x_r       <= '0;
            pix_y_r       <= '0;
            de_r          <= 1'b0;
            hsync_r       <= ~HS_ACT;
            vsync_r       <= ~VS_ACT;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_count_r <= '0;
            started_r     <= 1'b0;
        end else begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            if (vga.ce) begin
                pix_x_r       <= h_r;
                pix_y_r       <= v_r;
                de_r          <= de_s;
                hsync_r       <= hsync_s;
                vsync_r       <= vsync_s;
                line_start_r  <= (h_r == '0);
                frame_start_r <= at_origin_s;
                h_r           <= h_next_s;
                v_r           <= v_next_s;
                // The first origin after reset opens frame 0 rather than completing one.
                if (at_origin_s) begin
                    started_r <= 1'b1;
                    if (started_r) begin
                        frame_count_r <= frame_count_r + FRAME_W'(1);
                    end else begin
                        frame_count_r <= frame_count_r;
                    end
                end else begin
                    started_r     <= started_r;
                    frame_count_r <= frame_count_r;
                end
            end else begin
                h_r           <= h_r;
                v_r           <= v_r;
                pix_x_r       <= pix_x_r;
                pix_y_r       <= pix_y_r;
                de_r          <= de_r;
                hsync_r       <= hsync_r;
                vsync_r       <= vsync_r;
                frame_count_r <= frame_count_r;
                started_r     <= started_r;
            end
        end
    end

    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.de          = de_r;
    assign vga.pix_x       = pix_x_r;
    assign vga.pix_y       = pix_y_r;
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;
    assign vga.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 geometry plus a tiny 7x5 geometry, sharing clk/rst/ce,
// both compared every clock against a step-count reference model, plus directed timing measurements.
module tb_vga_timing_gen;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic ls;
        logic fs;
        int   x;
        int   y;
        int   fc;
    } exp_t;

    logic clk;
    logic rst;
    logic ce;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: ce steps since reset, and whether the last edge was a ce step.
    int k       = 0;
    bit stepped = 1'b0;
    bit valid   = 1'b0;

    vga_timing_if #(.CNT_W(11), .FRAME_W(8)) bus_a ();
    vga_timing_if #(.CNT_W(4),  .FRAME_W(2)) bus_b ();

    assign bus_a.ce = ce;
    assign bus_b.ce = ce;

    vga_timing_gen dut_a (
        .clk (clk),
        .rst (rst),
        .vga (bus_a.master)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_VISIBLE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CNT_W(4), .FRAME_W(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .vga (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs after k ce steps, straight from the raster rules.
    function automatic exp_t model_at(input int kk, input bit st,
                                      input int hv, input int hf, input int hsw, input int hb,
                                      input int vv, input int vf, input int vsw, input int vb,
                                      input bit hp, input bit vp, input int fw);
        exp_t e;
        int ht, vt, s;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (kk == 0) begin
            e.x = 0; e.y = 0; e.de = 1'b0; e.hs = !hp; e.vs = !vp;
            e.fc = 0; e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            s    = kk - 1;
            e.x  = s % ht;
            e.y  = (s / ht) % vt;
            e.de = (e.x < hv) && (e.y < vv);
            e.hs = (e.x >= hv + hf && e.x < hv + hf + hsw) ? hp : !hp;
            e.vs = (e.y >= vv + vf && e.y < vv + vf + vsw) ? vp : !vp;
            e.fc = (s / (ht * vt)) % (1 << fw);
            e.ls = st && (e.x == 0);
            e.fs = st && (e.x == 0) && (e.y == 0);
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t e,
                       input int hs, input int vs, input int de, input int ls, input int fs,
                       input int x, input int y, input int fc);
        check({nm, "_hsync"},       hs, int'(e.hs));
        check({nm, "_vsync"},       vs, int'(e.vs));
        check({nm, "_de"},          de, int'(e.de));
        check({nm, "_line_start"},  ls, int'(e.ls));
        check({nm, "_frame_start"}, fs, int'(e.fs));
        check({nm, "_pix_x"},       x,  e.x);
        check({nm, "_pix_y"},       y,  e.y);
        check({nm, "_frame_count"}, fc, e.fc);
    endtask

    // Reference model step on each active edge.
    always @(posedge clk) begin
        if (rst) begin
            k       = 0;
            stepped = 1'b0;
            valid   = 1'b1;
        end else if (ce) begin
            k       = k + 1;
            stepped = 1'b1;
        end else begin
            stepped = 1'b0;
        end
    end

    // Per-clock comparison of both instances against the model.
    always @(negedge clk) begin
        if (valid) begin
            cmp("a", model_at(k, stepped, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8),
                int'(bus_a.hsync), int'(bus_a.vsync), int'(bus_a.de), int'(bus_a.line_start),
                int'(bus_a.frame_start), int'(bus_a.pix_x), int'(bus_a.pix_y),
                int'(bus_a.frame_count));
            cmp("b", model_at(k, stepped, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0, 2),
                int'(bus_b.hsync), int'(bus_b.vsync), int'(bus_b.de), int'(bus_b.line_start),
                int'(bus_b.frame_start), int'(bus_b.pix_x), int'(bus_b.pix_y),
                int'(bus_b.frame_count));
        end
    end

    task automatic check_first_edge(input string nm);
        check({nm, "_x0"},  int'(bus_a.pix_x), 0);
        check({nm, "_y0"},  int'(bus_a.pix_y), 0);
        check({nm, "_de"},  int'(bus_a.de), 1);
        check({nm, "_ls"},  int'(bus_a.line_start), 1);
        check({nm, "_fs"},  int'(bus_a.frame_start), 1);
        check({nm, "_fc"},  int'(bus_a.frame_count), 0);
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_hsync"}, int'(bus_a.hsync), 1);
        check({nm, "_vsync"}, int'(bus_a.vsync), 1);
        check({nm, "_de"},    int'(bus_a.de), 0);
        check({nm, "_x"},     int'(bus_a.pix_x), 0);
        check({nm, "_y"},     int'(bus_a.pix_y), 0);
        check({nm, "_ls"},    int'(bus_a.line_start), 0);
        check({nm, "_fs"},    int'(bus_a.frame_start), 0);
        check({nm, "_fc"},    int'(bus_a.frame_count), 0);
        check({nm, "_b_hsync"}, int'(bus_b.hsync), 0);
    endtask

    initial begin
        bit found;
        int de_cnt, hs_lo, hs_first, hs_last, period, cyc;
        int ls_t[$];
        int fs_t[$];
        int fc_seen[$];

        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;
        @(negedge clk);
        check_first_edge("first");

        // Full-rate line structure on the default geometry.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (bus_a.line_start) found = 1'b1;
        end
        check("line_start_seen", int'(found), 1);
        de_cnt = 0; hs_lo = 0; hs_first = -1; hs_last = -1; period = 0;
        for (int i = 0; i < 800; i++) begin
            if (bus_a.de) de_cnt++;
            if (!bus_a.hsync) begin
                hs_lo++;
                if (hs_first < 0) hs_first = int'(bus_a.pix_x);
                hs_last = int'(bus_a.pix_x);
            end
            @(negedge clk);
            if (bus_a.line_start && period == 0) period = i + 1;
        end
        check("de_per_line", de_cnt, 640);
        check("hsync_low_len", hs_lo, 96);
        check("hsync_first_x", hs_first, 656);
        check("hsync_last_x", hs_last, 751);
        check("line_period", period, 800);

        // Half-rate ce: periods double.
        cyc = 0;
        while (cyc < 5000 && (ls_t.size() < 2 || fs_t.size() < 2)) begin
            ce = ~ce;
            @(negedge clk);
            cyc++;
            if (bus_a.line_start) ls_t.push_back(cyc);
            if (bus_b.frame_start) fs_t.push_back(cyc);
        end
        check("half_rate_seen", int'(ls_t.size() >= 2 && fs_t.size() >= 2), 1);
        if (ls_t.size() >= 2) check("half_line_period", ls_t[1] - ls_t[0], 1600);
        if (fs_t.size() >= 2) check("half_frame_period_b", fs_t[1] - fs_t[0], 70);

        // Small geometry: frame period and frame_count sequence from reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        fs_t.delete();
        for (int i = 0; i < 400 && fs_t.size() < 5; i++) begin
            @(negedge clk);
            if (bus_b.frame_start) begin
                fs_t.push_back(i);
                fc_seen.push_back(int'(bus_b.frame_count));
            end
        end
        check("b_frame_starts", fs_t.size(), 5);
        for (int j = 0; j < fs_t.size(); j++) begin
            check("b_frame_count", fc_seen[j], j % 4);
            if (j > 0) check("b_frame_period", fs_t[j] - fs_t[j-1], 35);
        end

        // Reset mid-line at pix_x=300.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (bus_a.pix_x == 11'd300) found = 1'b1;
        end
        check("midline_reached", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        @(negedge clk);
        check_first_edge("restart");

        // Random ce pattern with rare resets, checked by the per-clock model.
        for (int i = 0; i < 30000; i++) begin
            ce  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
